// File: rtl/bus_pkg.sv
// bus_pkg: shared bus widths, peripheral base addresses and master FSM state type
package bus_pkg;
    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;
    localparam logic [31:0] PWM0_BASE = 32'h0200_2000;
    localparam logic [31:0] PWM1_BASE = 32'h0200_3000;
    typedef enum logic [1:0] {ST_IDLE, ST_STROBE, ST_RESP} bus_state_e;
endpackage

// File: rtl/bus_timeout_cnt.sv
// bus_timeout_cnt: 8-bit strobe cycle counter flagging the last allowed strobe cycle
//   iCLK/iRST  clock, synchronous active-high reset
//   iCLR       zero the count (takes priority over iEN)
//   iEN        advance the count by one
//   oEXPIRE    count has reached TIMEOUT-1
module bus_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iCLR,
    input  logic iEN,
    output logic oEXPIRE
);
    logic [7:0] cnt_q, cnt_d;
    always_comb cnt_d = iCLR ? 8'd0 : iEN ? cnt_q + 8'd1 : cnt_q;
    always_ff @(posedge iCLK) cnt_q <= iRST ? 8'd0 : cnt_d;
    assign oEXPIRE = cnt_q == 8'(TIMEOUT - 1);
endmodule

// File: rtl/bus_master.sv
// bus_master: single-outstanding bus initiator with strobe timeout
//   iCLK/iRST                          clock, synchronous active-high reset
//   iCMD_VALID/oCMD_READY              command handshake (ready only when idle)
//   iCMD_WE/iCMD_ADR/iCMD_DAT          command: direction, address, write data
//   oRSP_VALID/oRSP_DAT/oRSP_ERR       one-cycle response pulse, read data, timeout flag
//   oADR/oDAT/oWE/oSTB                 bus initiator outputs
//   iACK/iDAT                          responder acknowledge and read data
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W  = BUS_ADDR_W,
    parameter int DATA_W  = BUS_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              iCMD_VALID,
    output logic              oCMD_READY,
    input  logic              iCMD_WE,
    input  logic [ADDR_W-1:0] iCMD_ADR,
    input  logic [DATA_W-1:0] iCMD_DAT,
    output logic              oRSP_VALID,
    output logic [DATA_W-1:0] oRSP_DAT,
    output logic              oRSP_ERR,
    output logic [ADDR_W-1:0] oADR,
    output logic [DATA_W-1:0] oDAT,
    output logic              oWE,
    output logic              oSTB,
    input  logic              iACK,
    input  logic [DATA_W-1:0] iDAT
);
    bus_state_e        state_q, state_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d, rsp_dat_q, rsp_dat_d;
    logic              we_q, we_d, stb_q, stb_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic              cnt_clr, cnt_en, cnt_expire;

    bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_cnt (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .iCLR    (cnt_clr),
        .iEN     (cnt_en),
        .oEXPIRE (cnt_expire)
    );

    // Response fields default to zero so they are only non-zero alongside oRSP_VALID.
    always_comb begin
        state_d     = state_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        stb_d       = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = '0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        case (state_q)
            ST_IDLE: if (iCMD_VALID) begin
                adr_d   = iCMD_ADR;
                dat_d   = iCMD_DAT;
                we_d    = iCMD_WE;
                stb_d   = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_STROBE;
            end
            // ACK is tested before expiry so an ACK on the final strobe cycle still succeeds.
            ST_STROBE: if (iACK) begin
                rsp_valid_d = 1'b1;
                rsp_dat_d   = we_q ? '0 : iDAT;
                state_d     = ST_RESP;
            end else if (cnt_expire) begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = ST_RESP;
            end else begin
                stb_d  = 1'b1;
                cnt_en = 1'b1;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            stb_q       <= stb_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign oCMD_READY = state_q == ST_IDLE;
    assign oRSP_VALID = rsp_valid_q;
    assign oRSP_DAT   = rsp_dat_q;
    assign oRSP_ERR   = rsp_err_q;
    assign oADR       = adr_q;
    assign oDAT       = dat_q;
    assign oWE        = we_q;
    assign oSTB       = stb_q;
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: directed checks of bus_master against a two-register PWM responder
module tb_bus_master;
    localparam logic [31:0] PWM0 = 32'h0200_2000;
    localparam logic [31:0] PWM1 = 32'h0200_3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0, cmd_dat = '0;
    logic        cmd_ready, rsp_valid, rsp_err, we, stb, ack;
    logic [31:0] rsp_dat, adr, dat, idat;
    logic        man_mode = 1'b0, man_ack = 1'b0;
    logic [31:0] pwm0, pwm1;

    int          n_checks = 0, n_fail = 0;
    int          stb_n, lat;
    logic        got, stable, r_err;
    logic [31:0] r_dat;

    always #5 clk = ~clk;

    bus_master dut (
        .iCLK       (clk),
        .iRST       (rst),
        .iCMD_VALID (cmd_valid),
        .oCMD_READY (cmd_ready),
        .iCMD_WE    (cmd_we),
        .iCMD_ADR   (cmd_adr),
        .iCMD_DAT   (cmd_dat),
        .oRSP_VALID (rsp_valid),
        .oRSP_DAT   (rsp_dat),
        .oRSP_ERR   (rsp_err),
        .oADR       (adr),
        .oDAT       (dat),
        .oWE        (we),
        .oSTB       (stb),
        .iACK       (ack),
        .iDAT       (idat)
    );

    // Responder: PWM0/PWM1 ack in the first strobe cycle; anything else never acks.
    assign idat = adr == PWM0 ? pwm0 : adr == PWM1 ? pwm1 : 32'hDEAD_BEEF;
    assign ack  = man_mode ? man_ack : stb && (adr == PWM0 || adr == PWM1);

    always @(posedge clk) begin
        if (rst) begin
            pwm0 <= 32'h0;
            pwm1 <= 32'h800;
        end else if (stb && ack && we) begin
            if (adr == PWM0) pwm0 <= dat;
            if (adr == PWM1) pwm1 <= dat;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one command from IDLE and runs until the response pulse (bounded).
    // man_at != 0: drive iACK by hand in cycle man_at after the accept edge.
    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input int man_at);
        cmd_we = w; cmd_adr = a; cmd_dat = d; cmd_valid = 1'b1;
        man_mode = man_at != 0; man_ack = 1'b0;
        tick();
        cmd_valid = 1'b0;
        stb_n = 0; lat = 0; got = 1'b0; stable = 1'b1; r_err = 1'b0; r_dat = '0;
        for (int i = 0; i < 64 && !got; i++) begin
            lat++;
            man_ack = man_at != 0 && lat == man_at;
            if (stb) begin
                stb_n++;
                if (adr !== a || dat !== d || we !== w) stable = 1'b0;
            end
            if (rsp_valid) begin
                got = 1'b1; r_err = rsp_err; r_dat = rsp_dat;
            end else tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (stb !== 1'b0) begin n_fail++; $display("FAIL reset_stb: got %b want 0", stb); end
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", we); end
        n_checks++; if (adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", adr); end
        n_checks++; if (dat !== 32'h0) begin n_fail++; $display("FAIL reset_dat: got %h want 0", dat); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_checks++; if (rsp_dat !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_dat: got %h want 0", rsp_dat); end
        rst = 1'b0;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        tick();
    endtask

    task automatic test_write_readback();
        run_cmd(1'b1, PWM0, 32'h400, 0);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_seen: got %b want 1", got); end
        n_checks++; if (stb_n != 1) begin n_fail++; $display("FAIL wr_stb_cycles: got %0d want 1", stb_n); end
        n_checks++; if (lat != 2) begin n_fail++; $display("FAIL wr_rsp_latency: got %0d want 2", lat); end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL wr_bus_stable: got %b want 1", stable); end
        n_checks++; if (r_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b want 0", r_err); end
        n_checks++; if (r_dat !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_dat: got %h want 0", r_dat); end
        tick();
        n_checks++; if ({cmd_ready, rsp_valid, stb} !== 3'b100) begin n_fail++; $display("FAIL wr_turnaround rdy/vld/stb: got %b want 100", {cmd_ready, rsp_valid, stb}); end
        n_checks++; if ({we, dat} !== {1'b1, 32'h400}) begin n_fail++; $display("FAIL wr_retain we/dat: got %b/%h want 1/00000400", we, dat); end
        run_cmd(1'b0, PWM0, 32'h0, 0);
        n_checks++; if ({got, r_err} !== 2'b10) begin n_fail++; $display("FAIL rd0_got_err: got %b want 10", {got, r_err}); end
        n_checks++; if (r_dat !== 32'h400) begin n_fail++; $display("FAIL rd0_data: got %h want 00000400", r_dat); end
        tick();
    endtask

    task automatic test_read_pwm1();
        run_cmd(1'b0, PWM1, 32'h0, 0);
        n_checks++; if ({got, r_err} !== 2'b10) begin n_fail++; $display("FAIL rd1_got_err: got %b want 10", {got, r_err}); end
        n_checks++; if (r_dat !== 32'h800) begin n_fail++; $display("FAIL rd1_data: got %h want 00000800", r_dat); end
        tick();
    endtask

    task automatic test_timeout();
        run_cmd(1'b0, 32'h0, 32'h0, 0);
        n_checks++; if (got !== 1'b1) begin n_fail++; $display("FAIL to_rsp_seen: got %b want 1", got); end
        n_checks++; if (stb_n != 16) begin n_fail++; $display("FAIL to_stb_cycles: got %0d want 16", stb_n); end
        n_checks++; if (lat != 17) begin n_fail++; $display("FAIL to_rsp_latency: got %0d want 17", lat); end
        n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b want 1", r_err); end
        n_checks++; if (r_dat !== 32'h0) begin n_fail++; $display("FAIL to_rsp_dat: got %h want 0", r_dat); end
        n_checks++; if (stable !== 1'b1) begin n_fail++; $display("FAIL to_bus_stable: got %b want 1", stable); end
        tick();
    endtask

    task automatic test_ack_boundary();
        logic late_bad;
        run_cmd(1'b0, PWM1, 32'h0, 16);
        n_checks++; if ({got, r_err} !== 2'b10) begin n_fail++; $display("FAIL ack16_got_err: got %b want 10", {got, r_err}); end
        n_checks++; if (stb_n != 16) begin n_fail++; $display("FAIL ack16_stb_cycles: got %0d want 16", stb_n); end
        n_checks++; if (r_dat !== 32'h800) begin n_fail++; $display("FAIL ack16_data: got %h want 00000800", r_dat); end
        man_ack = 1'b0;
        tick();
        run_cmd(1'b0, PWM1, 32'h0, 17);
        n_checks++; if ({got, r_err} !== 2'b11) begin n_fail++; $display("FAIL ack17_got_err: got %b want 11", {got, r_err}); end
        n_checks++; if (r_dat !== 32'h0) begin n_fail++; $display("FAIL ack17_data: got %h want 0", r_dat); end
        late_bad = 1'b0;
        repeat (3) begin
            tick();
            if (rsp_valid !== 1'b0 || stb !== 1'b0) late_bad = 1'b1;
        end
        man_ack = 1'b0; man_mode = 1'b0;
        n_checks++; if (late_bad !== 1'b0) begin n_fail++; $display("FAIL late_ack_ignored: got %b want 0", late_bad); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL late_ack_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  s, v, r;
        logic [31:0] dat_idle, dat_second;
        cmd_we = 1'b1; cmd_adr = PWM0; cmd_dat = 32'h111; cmd_valid = 1'b1;
        tick();
        cmd_dat = 32'h222;
        for (int k = 0; k < 6; k++) begin
            s[5-k] = stb; v[5-k] = rsp_valid; r[5-k] = cmd_ready;
            if (k == 2) dat_idle = dat;
            if (k == 3) begin dat_second = dat; cmd_valid = 1'b0; end
            tick();
        end
        n_checks++; if (s !== 6'b100100) begin n_fail++; $display("FAIL b2b_stb: got %b want 100100", s); end
        n_checks++; if (v !== 6'b010010) begin n_fail++; $display("FAIL b2b_rsp_valid: got %b want 010010", v); end
        n_checks++; if (r !== 6'b001001) begin n_fail++; $display("FAIL b2b_ready: got %b want 001001", r); end
        n_checks++; if (dat_idle !== 32'h111) begin n_fail++; $display("FAIL b2b_dat_hold: got %h want 00000111", dat_idle); end
        n_checks++; if (dat_second !== 32'h222) begin n_fail++; $display("FAIL b2b_dat_second: got %h want 00000222", dat_second); end
    endtask

    task automatic test_reset_mid();
        logic spurious;
        cmd_we = 1'b0; cmd_adr = 32'h0; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        n_checks++; if (stb !== 1'b1) begin n_fail++; $display("FAIL rmid_stb_before: got %b want 1", stb); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if ({stb, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL rmid_stb_vld: got %b want 00", {stb, rsp_valid}); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %b want 1", cmd_ready); end
        n_checks++; if (adr !== 32'h0) begin n_fail++; $display("FAIL rmid_adr: got %h want 0", adr); end
        spurious = 1'b0;
        repeat (20) begin
            tick();
            if (rsp_valid !== 1'b0 || stb !== 1'b0) spurious = 1'b1;
        end
        n_checks++; if (spurious !== 1'b0) begin n_fail++; $display("FAIL rmid_silent: got %b want 0", spurious); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_readback();
        test_read_pwm1();
        test_timeout();
        test_ack_boundary();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter ADDR_W, default 32, bus address width.
REQ-002 Parameter DATA_W, default 32, bus data width.
REQ-003 Parameter TIMEOUT, default 16, maximum strobe cycles before abort; legal range 2..255.
REQ-004 iCLK  in  1  single clock; all logic SHALL be rising-edge.
REQ-005 iRST  in  1  reset, synchronous, active-high.
REQ-006 iCMD_VALID  in  1  command request.
REQ-007 oCMD_READY  out  1  command accepted this edge when high with iCMD_VALID.
REQ-008 iCMD_WE  in  1  1 = write, 0 = read.
REQ-009 iCMD_ADR  in  ADDR_W  target address.
REQ-010 iCMD_DAT  in  DATA_W  write data.
REQ-011 oRSP_VALID  out  1  one-cycle response pulse.
REQ-012 oRSP_DAT  out  DATA_W  read data (0 for writes and errors).
REQ-013 oRSP_ERR  out  1  timeout flag, valid with oRSP_VALID.
REQ-014 oADR / oDAT / oWE / oSTB  out  ADDR_W / DATA_W / 1 / 1  bus initiator outputs to address decoder and peripherals.
REQ-015 iACK  in  1  responder acknowledge; iDAT  in  DATA_W  responder read data (pre-muxed).

Function
REQ-016 FSM states SHALL be IDLE, STROBE, RESP; oCMD_READY = 1 only in IDLE.
REQ-017 On accept edge (IDLE, iCMD_VALID=1) SHALL register iCMD_ADR/DAT/WE onto oADR/oDAT/oWE, set oSTB=1, clear strobe counter, enter STROBE.
REQ-018 oADR, oDAT, oWE SHALL be stable for the whole time oSTB=1 and SHALL retain last values afterwards.
REQ-019 In STROBE, edge with iACK=1: oSTB->0, oRSP_VALID->1, oRSP_ERR->0, oRSP_DAT <- iDAT if read else 0, enter RESP.
REQ-020 In STROBE, edge with iACK=0: counter +1; when counter reaches TIMEOUT-1 (oSTB high TIMEOUT cycles) SHALL drop oSTB, pulse oRSP_VALID with oRSP_ERR=1, oRSP_DAT=0, enter RESP.
REQ-021 iACK on the same edge as timeout expiry: ACK SHALL win (success response).
REQ-022 RESP lasts exactly one cycle (oRSP_VALID=1, oSTB=0), then IDLE; oRSP_VALID SHALL be 0 in all other cycles.
REQ-023 Minimum turnaround: accept edge N, oSTB high in cycle N+1, ACK at edge N+1, oRSP_VALID in cycle N+2, oCMD_READY in cycle N+3; oSTB SHALL be low at least 2 cycles between strobes.
REQ-024 iACK while oSTB=0 SHALL be ignored; iCMD_VALID outside IDLE SHALL be ignored (no queuing).
REQ-025 Response has no back-pressure; consumer SHALL sample oRSP_VALID pulse.
REQ-026 Counter width SHALL be 8 bits; no wrap possible within legal TIMEOUT.

Reset
REQ-027 iRST=1 at an edge SHALL force IDLE, counter 0, oSTB=0, oWE=0, oADR=0, oDAT=0, oRSP_VALID=0, oRSP_ERR=0, oRSP_DAT=0.
REQ-028 Reset mid-transaction SHALL abort silently: no oRSP_VALID; oCMD_READY=1 first cycle after iRST deasserts.

Structure
REQ-029 Shared package bus_pkg SHALL hold the FSM state type, ADDR_W/DATA_W defaults, and peripheral base constants PWM0_BASE=0x0200_2000, PWM1_BASE=0x0200_3000.
REQ-030 One sub-module bus_timeout_cnt (clear, enable, expire output) SHALL implement the strobe counter; all else in bus_master.

Verification
REQ-031 Write 0x0200_2000 data 0x400 to PWM_IP -> oSTB 1 cycle, oWE=1, oDAT=0x400, oRSP_VALID pulse, ERR=0; read back -> oRSP_DAT=0x400.
REQ-032 Read 0x0200_3000 after reset -> oRSP_DAT=0x800, ERR=0.
REQ-033 Read unmapped 0x0000_0000 (no ACK) -> oSTB high exactly 16 cycles, then oRSP_VALID, ERR=1, oRSP_DAT=0.
REQ-034 Responder model ACKs in strobe cycle 16 -> success, ERR=0; model ACKs in cycle 17 -> ERR=1 and late ACK ignored.
REQ-035 iCMD_VALID held high for two commands -> second accepted only in cycle after RESP; oSTB low 2 cycles between.
REQ-036 iRST pulsed while oSTB=1 -> oSTB=0 next cycle, no oRSP_VALID, oCMD_READY=1 after release.
